// File: rtl/axi_read_responder.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_responder
// Summary  : AXI4 read-channel responder backed by a preloadable 64-bit word
//            memory. FIXED/INCR/WRAP bursts, OKAY/SLVERR/DECERR per beat.
// Option   : define AXI_RSP_BUBBLE_EN to insert a one-cycle rvalid gap after
//            every accepted odd, non-last beat.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_responder #(
  parameter int          DEPTH        = 1024,
  parameter int          READ_LATENCY = 2,
  parameter logic [63:0] BASE_ADDR    = 64'h0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     m_axi_arvalid,
  output logic                     m_axi_arready,
  input  logic [63:0]              m_axi_araddr,
  input  logic [7:0]               m_axi_arlen,
  input  logic [2:0]               m_axi_arsize,
  input  logic [1:0]               m_axi_arburst,
  output logic                     m_axi_rvalid,
  input  logic                     m_axi_rready,
  output logic [63:0]              m_axi_rdata,
  output logic [1:0]               m_axi_rresp,
  output logic                     m_axi_rlast,
  input  logic                     mem_we,
  input  logic [$clog2(DEPTH)-1:0] mem_waddr,
  input  logic [63:0]              mem_wdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

`ifdef AXI_RSP_BUBBLE_EN
  localparam bit BUBBLE_EN = 1'b1;
`else
  localparam bit BUBBLE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_BURST = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     addr_q, addr_d;
  logic [7:0]      len_q, len_d;
  logic [1:0]      burst_q, burst_d;
  logic            slverr_q, slverr_d;
  logic [7:0]      beat_q, beat_d;
  logic            arready_q, arready_d;
  logic            rvalid_q, rvalid_d;
  logic            rlast_q, rlast_d;
  logic [1:0]      rresp_q, rresp_d;
  logic            ok_q, ok_d;
  logic            bubble_q, bubble_d;

  logic [63:0]     mem_q [DEPTH];
  logic [63:0]     rd_q;

  logic [63:0]     wrap_mask;
  logic [63:0]     addr_inc;
  logic [63:0]     next_addr;
  logic [63:0]     sel_addr;
  logic [64:0]     sel_off;
  logic            sel_decerr;
  logic [1:0]      sel_resp;
  logic [IW-1:0]   rd_idx;
  logic            wrap_len_ok;
  logic            load;
  logic            load_last;

  // Wrap container is (len+1)*8 bytes; only meaningful for legal wrap lengths.
  assign wrap_mask = {53'd0, len_q, 3'b111};
  assign addr_inc  = addr_q + 64'd8;

  always_comb begin
    case (burst_q)
      BURST_FIXED: next_addr = addr_q;
      BURST_WRAP:  next_addr = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
      default:     next_addr = addr_inc;
    endcase
  end

  // Beat 0 comes from the captured address, later beats from the advanced one.
  assign sel_addr   = (state_q == S_WAIT) ? addr_q : next_addr;
  assign sel_off    = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
  assign sel_decerr = sel_off[64] || (sel_off[63:3] >= 61'(DEPTH));
  assign sel_resp   = slverr_q   ? RESP_SLVERR :
                      sel_decerr ? RESP_DECERR : RESP_OKAY;
  assign rd_idx     = sel_off[IW+2:3];

  assign wrap_len_ok = (m_axi_arlen == 8'd1) || (m_axi_arlen == 8'd3) ||
                       (m_axi_arlen == 8'd7) || (m_axi_arlen == 8'd15);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    slverr_d  = slverr_q;
    beat_d    = beat_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rresp_d   = rresp_q;
    ok_d      = ok_q;
    bubble_d  = bubble_q;
    load      = 1'b0;
    load_last = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m_axi_arvalid && arready_q) begin
          addr_d    = m_axi_araddr;
          len_d     = m_axi_arlen;
          burst_d   = m_axi_arburst;
          slverr_d  = (m_axi_arsize != 3'd3) || (m_axi_arburst == BURST_RSVD) ||
                      ((m_axi_arburst == BURST_WRAP) && !wrap_len_ok);
          beat_d    = 8'd0;
          cnt_d     = CW'(READ_LATENCY - 1);
          arready_d = 1'b0;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          load      = 1'b1;
          load_last = (len_q == 8'd0);
          state_d   = S_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        if (bubble_q) begin
          rvalid_d = 1'b1;
          bubble_d = 1'b0;
        end else if (rvalid_q && m_axi_rready) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            rresp_d   = RESP_OKAY;
            ok_d      = 1'b0;
            arready_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            load      = 1'b1;
            beat_d    = beat_q + 8'd1;
            load_last = ((beat_q + 8'd1) == len_q);
            bubble_d  = BUBBLE_EN && beat_q[0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (load) begin
      addr_d   = sel_addr;
      rvalid_d = !bubble_d;
      rlast_d  = load_last;
      rresp_d  = sel_resp;
      ok_d     = (sel_resp == RESP_OKAY);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      slverr_q  <= 1'b0;
      beat_q    <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      ok_q      <= 1'b0;
      bubble_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      slverr_q  <= slverr_d;
      beat_q    <= beat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      ok_q      <= ok_d;
      bubble_q  <= bubble_d;
    end
  end

  // Unreset storage so it maps onto block RAM; preload writes only land in IDLE.
  always_ff @(posedge clock) begin
    if (mem_we && (state_q == S_IDLE)) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
    if (load) begin
      rd_q <= mem_q[rd_idx];
    end
  end

  assign m_axi_arready = arready_q;
  assign m_axi_rvalid  = rvalid_q;
  assign m_axi_rlast   = rlast_q;
  assign m_axi_rresp   = rresp_q;
  assign m_axi_rdata   = ok_q ? rd_q : 64'd0;

endmodule
`default_nettype wire

// File: tb/tb_axi_read_responder.sv
`default_nettype none
// Testbench for axi_read_responder: directed bursts scored against a queue-based
// burst model, with literal expectations pinning the model on key beats.
module tb_axi_read_responder;

  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam logic [63:0] BASE  = 64'h0;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [63:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = 3'd3;
  logic [1:0]  arburst = 2'd1;
  logic        rvalid;
  logic        rready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        mem_we = 1'b0;
  logic [9:0]  mem_waddr = '0;
  logic [63:0] mem_wdata = '0;

  always #5 clock = ~clock;

  axi_read_responder #(
    .DEPTH(DEPTH), .READ_LATENCY(LAT), .BASE_ADDR(BASE)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
    .m_axi_arlen(arlen), .m_axi_arsize(arsize), .m_axi_arburst(arburst),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready), .m_axi_rdata(rdata),
    .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata)
  );

  int n_pass = 0;
  int n_total = 0;

  logic [63:0] model_mem [DEPTH];
  logic [63:0] base_addr;
  logic [63:0] exp_data [$];
  logic [1:0]  exp_resp [$];
  bit          exp_last [$];
  logic [63:0] obs_data [$];
  logic [1:0]  obs_resp [$];
  bit          obs_last [$];

  bit          expect_idle = 0;
  bit          stall_prev = 0;
  logic [63:0] pv_data;
  logic [1:0]  pv_resp;
  logic        pv_last;

  bit          toggle_mode = 0;
  logic [3:0]  rr_pat = 4'b1001;
  int          rr_cnt = 0;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Model: derive every beat of a burst from the protocol rules directly.
  task automatic build_exp(input logic [63:0] a0, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    logic [63:0] a, cont, wbase, widx;
    bit slv;
    int nb;
    nb   = int'(l) + 1;
    slv  = (s != 3'd3) || (b == 2'd3) ||
           ((b == 2'd2) && !(l == 8'd1 || l == 8'd3 || l == 8'd7 || l == 8'd15));
    cont = 64'(nb) * 64'd8;
    a    = a0;
    for (int i = 0; i < nb; i++) begin
      widx = (a - base_addr) / 64'd8;
      if (slv) begin
        exp_data.push_back(64'd0); exp_resp.push_back(2'd2);
      end else if (a < base_addr || widx >= 64'(DEPTH)) begin
        exp_data.push_back(64'd0); exp_resp.push_back(2'd3);
      end else begin
        exp_data.push_back(model_mem[int'(widx)]); exp_resp.push_back(2'd0);
      end
      exp_last.push_back(i == nb - 1);
      if (b == 2'd0) begin
        a = a;
      end else if (b == 2'd2) begin
        wbase = a - (a % cont);
        a     = wbase + ((a - wbase + 64'd8) % cont);
      end else begin
        a = a + 64'd8;
      end
    end
  endtask

  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (toggle_mode) begin
        rready = rr_pat[rr_cnt % 4];
        rr_cnt++;
      end else begin
        rready = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n) begin
      if (expect_idle) begin
        chk(arready && !rvalid, "idle_after_last", {62'd0, arready, rvalid}, 64'h2);
        expect_idle = 0;
      end
      if (stall_prev) begin
        chk(rvalid, "stall_rvalid_held", 64'(rvalid), 64'd1);
        chk(rdata == pv_data, "stall_rdata_held", rdata, pv_data);
        chk(rresp == pv_resp && rlast == pv_last, "stall_resp_last_held",
            {61'd0, rresp, rlast}, {61'd0, pv_resp, pv_last});
      end
      if (rvalid) chk(!arready, "arready_low_in_burst", 64'(arready), 64'd0);
      if (rvalid && rready) begin
        if (exp_data.size() == 0) begin
          chk(1'b0, "unexpected_beat", rdata, 64'd0);
        end else begin
          chk(rdata == exp_data[0], "rdata", rdata, exp_data[0]);
          chk(rresp == exp_resp[0], "rresp", 64'(rresp), 64'(exp_resp[0]));
          chk(rlast == exp_last[0], "rlast", 64'(rlast), 64'(exp_last[0]));
          if (exp_last[0]) expect_idle = 1;
          void'(exp_data.pop_front()); void'(exp_resp.pop_front()); void'(exp_last.pop_front());
        end
        obs_data.push_back(rdata); obs_resp.push_back(rresp); obs_last.push_back(rlast);
      end
      stall_prev = rvalid && !rready;
      pv_data = rdata; pv_resp = rresp; pv_last = rlast;
    end
  end

  task automatic preload(input int idx, input logic [63:0] d);
    mem_we = 1'b1; mem_waddr = 10'(idx); mem_wdata = d;
    model_mem[idx] = d;
    @(posedge clock); #1;
    mem_we = 1'b0;
  endtask

  task automatic issue_ar(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b);
    int t = 0;
    while (!arready && t < 50) begin @(posedge clock); #1; t++; end
    chk(arready, "arready_wait", 64'(arready), 64'd1);
    araddr = a; arlen = l; arsize = s; arburst = b; arvalid = 1'b1;
    obs_data.delete(); obs_resp.delete(); obs_last.delete();
    build_exp(a, l, s, b);
    @(posedge clock); #1;
    arvalid = 1'b0; mem_we = 1'b0;
  endtask

  task automatic check_latency();
    int n = 0;
    do begin @(negedge clock); n++; end while (!rvalid && n < 20);
    chk(rvalid && (n - 1) == LAT, "first_rvalid_latency", 64'(n - 1), 64'(LAT));
  endtask

  task automatic wait_done(input string nm);
    int t = 0;
    while (exp_data.size() != 0 && t < 300) begin @(posedge clock); #1; t++; end
    chk(exp_data.size() == 0, nm, 64'(exp_data.size()), 64'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
  endtask

  initial begin
    logic [10:0] pat, pat_exp;
    int t;
    base_addr = BASE;
    repeat (2) @(posedge clock);
    #1;
    chk(arready == 1'b1, "reset_arready", 64'(arready), 64'd1);
    chk(rvalid == 1'b0 && rlast == 1'b0, "reset_rvalid_rlast", {62'd0, rvalid, rlast}, 64'd0);
    chk(rdata == 64'd0 && rresp == 2'd0, "reset_rdata_rresp", rdata | 64'(rresp), 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 8; i++) preload(i, 64'h1000 + 64'(i));

    // INCR 8 beats, rready high
    issue_ar(64'h0, 8'd7, 3'd3, 2'd1);
    check_latency();
    wait_done("incr8_done");
    chk(obs_data.size() == 8, "incr8_beats", 64'(obs_data.size()), 64'd8);
    chk(obs_data[0] == 64'h1000, "incr8_beat0", obs_data[0], 64'h1000);
    chk(obs_data[7] == 64'h1007 && obs_last[7], "incr8_beat7", obs_data[7], 64'h1007);

    // WRAP 8 beats from 0x28
    issue_ar(64'h28, 8'd7, 3'd3, 2'd2);
    check_latency();
    wait_done("wrap8_done");
    chk(obs_data[0] == 64'h1005, "wrap_beat0", obs_data[0], 64'h1005);
    chk(obs_data[3] == 64'h1000, "wrap_beat3", obs_data[3], 64'h1000);
    chk(obs_data[7] == 64'h1004 && obs_last[7], "wrap_beat7", obs_data[7], 64'h1004);

    // INCR 4 beats with stalling initiator
    toggle_mode = 1; rr_cnt = 0;
    issue_ar(64'h0, 8'd3, 3'd3, 2'd1);
    check_latency();
    wait_done("stall_done");
    toggle_mode = 0;
    @(posedge clock); #1;
    chk(obs_data.size() == 4, "stall_beats", 64'(obs_data.size()), 64'd4);
    chk(obs_data[3] == 64'h1003, "stall_beat3", obs_data[3], 64'h1003);

    // Top-of-memory boundary: two OKAY then two DECERR
    preload(1022, 64'hA5A5_0000_0000_03FE);
    preload(1023, 64'hA5A5_0000_0000_03FF);
    issue_ar(64'h1FF0, 8'd3, 3'd3, 2'd1);
    check_latency();
    wait_done("bound_done");
    chk(obs_data[1] == 64'hA5A5_0000_0000_03FF, "bound_beat1", obs_data[1], 64'hA5A5_0000_0000_03FF);
    chk(obs_resp[2] == 2'd3 && obs_data[2] == 64'd0, "bound_beat2_decerr", 64'(obs_resp[2]), 64'd3);

    // Illegal size and illegal wrap length
    issue_ar(64'h0, 8'd1, 3'd2, 2'd1);
    wait_done("slverr_size_done");
    chk(obs_resp[1] == 2'd2 && obs_data.size() == 2, "slverr_size", 64'(obs_resp[1]), 64'd2);
    issue_ar(64'h0, 8'd2, 3'd3, 2'd2);
    wait_done("slverr_wrap_done");
    chk(obs_data.size() == 3 && obs_resp[0] == 2'd2, "slverr_wrap", 64'(obs_data.size()), 64'd3);

    // FIXED burst repeats one word
    issue_ar(64'h10, 8'd3, 3'd3, 2'd0);
    wait_done("fixed_done");
    chk(obs_data[3] == 64'h1002, "fixed_beat3", obs_data[3], 64'h1002);

    // Preload write on the AR handshake edge is visible to the burst
    mem_we = 1'b1; mem_waddr = 10'd5; mem_wdata = 64'hBEEF_0005; model_mem[5] = 64'hBEEF_0005;
    issue_ar(64'h28, 8'd0, 3'd3, 2'd1);
    wait_done("we_same_edge_done");
    chk(obs_data[0] == 64'hBEEF_0005, "we_same_edge", obs_data[0], 64'hBEEF_0005);

    // Preload write while busy is dropped
    issue_ar(64'h0, 8'd0, 3'd3, 2'd1);
    mem_we = 1'b1; mem_waddr = 10'd0; mem_wdata = 64'hDEAD_0000;
    @(posedge clock); #1;
    mem_we = 1'b0;
    wait_done("we_busy_done");
    chk(obs_data[0] == 64'h1000, "we_busy_dropped", obs_data[0], 64'h1000);

    // Reset during beat 3 of an 8-beat burst, then a fresh burst
    issue_ar(64'h0, 8'd7, 3'd3, 2'd1);
    t = 0;
    while (exp_data.size() > 5 && t < 50) begin @(posedge clock); #1; t++; end
    reset_n = 1'b0;
    #1;
    chk(!rvalid && !rlast, "midreset_rvalid", {62'd0, rvalid, rlast}, 64'd0);
    chk(arready, "midreset_arready", 64'(arready), 64'd1);
    chk(rdata == 64'd0 && rresp == 2'd0, "midreset_rdata", rdata, 64'd0);
    exp_data.delete(); exp_resp.delete(); exp_last.delete();
    expect_idle = 0; stall_prev = 0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
    issue_ar(64'h8, 8'd3, 3'd3, 2'd1);
    check_latency();
    wait_done("post_reset_done");
    chk(obs_data[0] == 64'h1001 && obs_data.size() == 4, "post_reset_beat0", obs_data[0], 64'h1001);

    // rvalid pattern with rready held high
    issue_ar(64'h0, 8'd7, 3'd3, 2'd1);
    check_latency();
    pat = '0;
    pat[10] = rvalid;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clock);
      pat[i] = rvalid;
    end
`ifdef AXI_RSP_BUBBLE_EN
    pat_exp = 11'b110_1101_1011;
`else
    pat_exp = 11'b111_1111_1000;
`endif
    chk(pat == pat_exp, "rvalid_pattern", 64'(pat), 64'(pat_exp));
    wait_done("pattern_done");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
